// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB register-file slave with read-only ID word, wait states and error decode
// Transfer: IDLE -> SETUP -> ACCESS. Decode and write use values captured when ACCESS is entered.
module apb_reg_slave #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [dataWidth-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [addrWidth-1:0]   paddr,
  input  logic [dataWidth-1:0]   pwdata,
  input  logic [dataWidth/8-1:0] pstrb,
  input  logic [2:0]             pprot,
  output logic                   pready,
  output logic                   pslverr,
  output logic [dataWidth-1:0]   prdata
);

  localparam int idxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} stateT;

  stateT                  state;
  stateT                  nextState;
  logic [3:0]             cnt;
  logic                   load;
  logic                   done;
  logic                   err;
  logic                   capWrite;
  logic                   capPriv;
  logic [addrWidth-1:0]   capAddr;
  logic [dataWidth-1:0]   capWdata;
  logic [dataWidth/8-1:0] capStrb;
  logic [addrWidth-3:0]   wordIdx;
  logic [idxW-1:0]        capIdx;
  logic [dataWidth-1:0]   regFile [NUM_REGS];
  logic                   unusedProt;

  assign unusedProt = ^pprot[2:1];

  assign wordIdx = capAddr[addrWidth-1:2];
  assign capIdx  = capAddr[idxW+1:2];
  assign err = (capAddr[1:0] != 2'b00)
            || (wordIdx >= (addrWidth-2)'(NUM_REGS))
            || (capWrite && (wordIdx == '0))
            || (capWrite && !capPriv && (wordIdx >= (addrWidth-2)'(NUM_REGS/2)));

  assign done    = (state == ACCESS) && (cnt == 4'(WAIT_STATES));
  assign pready  = done;
  assign pslverr = done && err;
  assign prdata  = (done && !err && !capWrite)
                 ? ((capIdx == '0) ? ID_VALUE : regFile[capIdx]) : '0;

  always_comb begin
    nextState = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) nextState = SETUP;
      end
      SETUP: begin
        if (psel && penable) begin
          nextState = ACCESS;
          load      = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      ACCESS: begin
        // Completion ignores the bus; an early drop of psel/penable aborts.
        if (done) nextState = (psel && !penable) ? SETUP : IDLE;
        else if (!(psel && penable)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      capWrite <= 1'b0;
      capPriv  <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
      capStrb  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      state <= nextState;
      if (load) begin
        cnt      <= '0;
        capWrite <= pwrite;
        capPriv  <= pprot[0];
        capAddr  <= paddr;
        capWdata <= pwdata;
        capStrb  <= pstrb;
      end else if ((state == ACCESS) && (cnt != 4'(WAIT_STATES))) begin
        cnt <= cnt + 4'd1;
      end
      if (done && capWrite && !err) begin
        for (int b = 0; b < dataWidth/8; b++) begin
          if (capStrb[b]) regFile[capIdx][8*b +: 8] <= capWdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - randomized and directed bench for apb_reg_slave against a transaction-level model
// dut0 runs with no wait states, dut1 with three; each cycle both are compared with the model.
module tb_apb_reg_slave;

  logic        clk;
  logic        rst     [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [2:0]  pprot   [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];

  logic        expReady [2];
  logic        expErr   [2];
  logic [31:0] expData  [2];
  logic [31:0] mdl [2][16];

  int nErr;
  int nChk;
  int cyc;
  bit checkOn;

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pprot(pprot[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0])
  );

  apb_reg_slave #(.WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pprot(pprot[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("pready%0d", d), {31'b0, pready[d]}, {31'b0, expReady[d]});
        check($sformatf("pslverr%0d", d), {31'b0, pslverr[d]}, {31'b0, expErr[d]});
        check($sformatf("prdata%0d", d), prdata[d], expData[d]);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input int d, input logic r, input logic e, input logic [31:0] data);
    expReady[d] = r;
    expErr[d]   = e;
    expData[d]  = data;
  endtask

  function automatic bit mdlErr(input bit wr, input logic [31:0] a, input logic [2:0] p);
    int unsigned idx;
    idx = a / 4;
    return (a % 4 != 0) || (idx >= 16) || (wr && idx == 0) || (wr && !p[0] && idx >= 8);
  endfunction

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int dropAt,
                      output logic [31:0] gotData, output bit gotErr, output int gotWait,
                      output int doneCyc);
    int ws;
    int unsigned idx;
    bit e;
    ws = (d == 0) ? 0 : 3;
    idx = addr / 4;
    gotData = '0;
    gotErr  = 1'b0;
    gotWait = 0;
    doneCyc = -1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
    pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    if (dropAt == 0) begin
      psel[d] = 1'b0;
      nextCycle();
      setExp(d, 1'b0, 1'b0, '0);
      return;
    end
    penable[d] = 1'b1;
    for (int k = 0; k <= ws; k++) begin
      nextCycle();
      paddr[d]  = $urandom;
      pwdata[d] = $urandom;
      if (k < ws) begin
        setExp(d, 1'b0, 1'b0, '0);
        if (!pready[d]) gotWait++;
        if (dropAt == k + 1) begin
          psel[d] = 1'b0;
          penable[d] = 1'b0;
          nextCycle();
          setExp(d, 1'b0, 1'b0, '0);
          return;
        end
      end else begin
        e = mdlErr(wr, addr, prot);
        if (wr || e) setExp(d, 1'b1, e, '0);
        else setExp(d, 1'b1, 1'b0, (idx == 0) ? 32'hA9B0_0001 : mdl[d][idx]);
        gotData = prdata[d];
        gotErr  = pslverr[d];
        if (pready[d]) doneCyc = cyc;
        if (wr && !e) begin
          for (int b = 0; b < 4; b++) begin
            if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
  endtask

  task automatic idle(input int d, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      psel[d] = glitch;
      penable[d] = glitch;
      nextCycle();
      setExp(d, 1'b0, 1'b0, '0);
    end
    psel[d] = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic rstAbort(input int d, input logic [31:0] addr, input logic [31:0] wdata);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr;
    pwdata[d] = wdata; pstrb[d] = 4'hF; pprot[d] = 3'b001;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    penable[d] = 1'b1;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    rst[d] = 1'b1;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) mdl[d][i] = '0;
    check("rst_abort_pready", {31'b0, pready[d]}, 32'h0);
    nextCycle();
    rst[d] = 1'b0;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    nextCycle();
    setExp(d, 1'b0, 1'b0, '0);
  endtask

  logic [31:0] rd;
  bit          er;
  int          w;
  int          c1;
  int          c2;
  bit          eWr   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] eAddr [4] = '{32'h00, 32'h40, 32'h06, 32'h20};
  logic [2:0]  eProt [4] = '{3'b001, 3'b001, 3'b001, 3'b000};

  initial begin
    checkOn = 1'b0;
    nErr = 0;
    nChk = 0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
      setExp(d, 1'b0, 1'b0, '0);
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
    end
    repeat (3) nextCycle();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    nextCycle();
    checkOn = 1'b1;
    check("reset_pready", {31'b0, pready[0]}, 32'h0);
    check("reset_pslverr", {31'b0, pslverr[0]}, 32'h0);
    check("reset_prdata", prdata[0], 32'h0);

    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, -1, rd, er, w, c1);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c2);
    check("rd04_data", rd, 32'hDEADBEEF);
    check("rd04_err", {31'b0, er}, 32'h0);
    check("ws0_xfer_len", 32'(c2 - c1), 32'd2);

    xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'b001, -1, rd, er, w, c1);
    xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b001, -1, rd, er, w, c1);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("strobe_merge", rd, 32'h11BB33DD);
    idle(0, 1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      xfer(0, eWr[k], eAddr[k], 32'h12345678, 4'hF, eProt[k], -1, rd, er, w, c1);
      check($sformatf("err_case%0d", k), {31'b0, er}, 32'h1);
      check($sformatf("err_case%0d_data", k), rd, 32'h0);
    end
    xfer(0, 1'b0, 32'h00, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("id_read", rd, 32'hA9B00001);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("rd20_unchanged", rd, 32'h0);

    xfer(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 3'b001, -1, rd, er, w, c1);
    check("zero_strb_err", {31'b0, er}, 32'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("zero_strb_keep", rd, 32'h11BB33DD);

    xfer(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b001, -1, rd, er, w, c1);
    idle(0, 2, 1'b1);
    xfer(0, 1'b1, 32'h10, 32'h0, 4'hF, 3'b001, 0, rd, er, w, c1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("setup_drop_keep", rd, 32'hCAFEF00D);
    idle(0, 1, 1'b0);

    xfer(1, 1'b1, 32'h04, 32'h01020304, 4'hF, 3'b001, -1, rd, er, w, c1);
    idle(1, 1, 1'b0);
    xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("ws3_wait_cycles", 32'(w), 32'd3);
    xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c2);
    check("ws3_b2b_len", 32'(c2 - c1), 32'd5);
    check("ws3_rd_data", rd, 32'h01020304);
    xfer(1, 1'b1, 32'h0C, 32'h00000055, 4'hF, 3'b001, -1, rd, er, w, c1);
    idle(1, 1, 1'b0);
    rstAbort(1, 32'h0C, 32'h77777777);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b001, -1, rd, er, w, c1);
    check("rd0c_after_rst", rd, 32'h0);
    idle(1, 1, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        logic [31:0] a;
        int drop;
        a = 32'($urandom_range(0, 19)) * 4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        drop = ($urandom_range(0, 9) == 0) ? ((d == 0) ? 0 : int'($urandom_range(0, 3))) : -1;
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 3'($urandom), drop,
             rd, er, w, c1);
        idle(d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
      idle(d, 1, 1'b0);
    end

    idle(0, 2, 1'b0);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
